passive_line_responder: RTL and testbench

// - ACE-lite responder for one 64-byte cache line; target side of the active-path read (AR/R/RACK) and write (AW/W/B/WACK) flows.
// - Holds the line plus its tag and answers 4-beat bursts of 128 bits.
// - Serves as the bench/loopback target for the active data-leak (read) and data-tampering (write) functions.

---
 rtl/passive_line_responder.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_passive_line_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passive_line_responder.sv
// passive_line_responder
// ACE-lite target holding one 64-byte cache line (4 x 128-bit beats) plus
// its tag. Serves wrap-ordered read bursts (AR/R/RACK) and strobed write
// bursts (AW/W/B/WACK). Only 4-beat bursts are legal; anything else is
// answered with SLVERR (zero data on reads, data still merged on writes).
// Optional feature macro: DEVIL_RESP_ERR_INJECT_EN (sticky B-channel
// SLVERR injection armed by i_err_inject while idle).
module passive_line_responder #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int C_DELAY_WIDTH    = 8
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]                    i_arlen,
    input  logic                          i_arvalid,
    output logic                          o_arready,
    output logic [C_ACE_DATA_WIDTH-1:0]   o_rdata,
    output logic [3:0]                    o_rresp,
    output logic                          o_rlast,
    output logic                          o_rvalid,
    input  logic                          i_rready,
    input  logic                          i_rack,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]                    i_awlen,
    input  logic                          i_awvalid,
    output logic                          o_awready,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_wdata,
    input  logic [C_ACE_DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                          i_wlast,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    output logic [1:0]                    o_bresp,
    output logic                          o_bvalid,
    input  logic                          i_bready,
    input  logic                          i_wack,
    input  logic [C_DELAY_WIDTH-1:0]      i_delay,
    input  logic                          i_err_inject,
    output logic [4*C_ACE_DATA_WIDTH-1:0] o_cache_line,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_line_addr,
    output logic                          o_busy
);

    localparam int DBW = C_ACE_DATA_WIDTH;
    localparam int AW  = C_ACE_ADDR_WIDTH;
    localparam int DW  = C_DELAY_WIDTH;

    localparam logic [3*DBW-1:0] BEATS3_ZERO = {(3*DBW){1'b0}};
    localparam logic [DBW-1:0]   BEAT_ZERO   = {DBW{1'b0}};
    localparam logic [DW-1:0]    DLY_ZERO    = {DW{1'b0}};
    localparam logic [DW-1:0]    DLY_ONE     = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_R_WAIT = 3'd1,
        S_R_DATA = 3'd2,
        S_R_ACK  = 3'd3,
        S_W_DATA = 3'd4,
        S_B_RESP = 3'd5,
        S_W_ACK  = 3'd6
    } state_e;

    // Byte-strobed merge of one write beat into an existing line beat.
    function automatic logic [DBW-1:0] merge_beat(input logic [DBW-1:0]   old_v,
                                                  input logic [DBW-1:0]   new_v,
                                                  input logic [DBW/8-1:0] strb);
        logic [DBW-1:0] res;
        res = old_v;
        for (int b = 0; b < DBW/8; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_e                 state_q, state_d;
    logic [3:0][DBW-1:0]    line_q, line_d;
    logic [AW-7:0]          tag_q, tag_d;
    logic                   valid_q, valid_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [DW-1:0]          delay_q, delay_d;
    logic                   hit_q, hit_d;
    logic                   rerr_q, rerr_d;
    logic                   werr_q, werr_d;
    logic [DBW-1:0]         rdata_q, rdata_d;
    logic [3:0]             rresp_q, rresp_d;
    logic                   rlast_q, rlast_d;
    logic                   rvalid_q, rvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   bvalid_q, bvalid_d;
    logic                   last_beat_s;
    logic                   inj_s;

`ifdef DEVIL_RESP_ERR_INJECT_EN
    logic inj_q, inj_d;

    // Sticky inject flag: armed while idle, consumed by the next B handshake.
    always_comb begin
        inj_d = inj_q;
        if (state_q == S_IDLE && i_err_inject) begin
            inj_d = 1'b1;
        end else if (state_q == S_B_RESP && i_bready) begin
            inj_d = 1'b0;
        end else begin
            inj_d = inj_q;
        end
    end

    // Inject flag register.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    assign inj_s = inj_q;

    logic unused_s;
    assign unused_s = ^{i_araddr[3:0], i_awaddr[3:0]};
`else
    assign inj_s = 1'b0;

    logic unused_s;
    assign unused_s = ^{i_araddr[3:0], i_awaddr[3:0], i_err_inject};
`endif

    // Next-state, line/tag update and next registered-output computation.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        delay_d     = delay_q;
        hit_d       = hit_q;
        rerr_d      = rerr_q;
        werr_d      = werr_q;
        last_beat_s = (cnt_q == len_q);

        case (state_q)
            S_IDLE: begin
                // Write has priority; arready is already masked by awvalid.
                if (i_awvalid) begin
                    len_d  = i_awlen;
                    idx_d  = i_awaddr[5:4];
                    cnt_d  = 8'd0;
                    werr_d = (i_awlen != 8'd3);
                    tag_d  = i_awaddr[AW-1:6];
                    valid_d = 1'b1;
                    if (!(valid_q && (i_awaddr[AW-1:6] == tag_q))) begin
                        line_d = {BEATS3_ZERO, BEAT_ZERO};
                    end else begin
                        line_d = line_q;
                    end
                    state_d = S_W_DATA;
                end else if (i_arvalid) begin
                    len_d   = i_arlen;
                    idx_d   = i_araddr[5:4];
                    cnt_d   = 8'd0;
                    hit_d   = valid_q && (i_araddr[AW-1:6] == tag_q);
                    rerr_d  = (i_arlen != 8'd3);
                    delay_d = i_delay;
                    if (i_delay == DLY_ZERO) begin
                        state_d = S_R_DATA;
                    end else begin
                        state_d = S_R_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_R_WAIT: begin
                // Leaving when the counter hits zero gives i_delay+1 cycles
                // from handshake to first visible rvalid.
                delay_d = delay_q - DLY_ONE;
                if (delay_q <= DLY_ONE) begin
                    state_d = S_R_DATA;
                end else begin
                    state_d = S_R_WAIT;
                end
            end
            S_R_DATA: begin
                if (i_rready) begin
                    cnt_d = cnt_q + 8'd1;
                    idx_d = idx_q + 2'd1;
                    if (last_beat_s) begin
                        state_d = S_R_ACK;
                    end else begin
                        state_d = S_R_DATA;
                    end
                end else begin
                    state_d = S_R_DATA;
                end
            end
            S_R_ACK: begin
                if (i_rack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_R_ACK;
                end
            end
            S_W_DATA: begin
                if (i_wvalid) begin
                    line_d[idx_q] = merge_beat(line_q[idx_q], i_wdata, i_wstrb);
                    idx_d = idx_q + 2'd1;
                    cnt_d = cnt_q + 8'd1;
                    if (i_wlast || last_beat_s) begin
                        werr_d  = werr_q | (i_wlast != last_beat_s);
                        state_d = S_B_RESP;
                    end else begin
                        state_d = S_W_DATA;
                    end
                end else begin
                    state_d = S_W_DATA;
                end
            end
            S_B_RESP: begin
                if (i_bready) begin
                    state_d = S_W_ACK;
                end else begin
                    state_d = S_B_RESP;
                end
            end
            S_W_ACK: begin
                if (i_wack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_W_ACK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered and derived from the next state so that
        // they line up with the state they describe.
        rvalid_d = (state_d == S_R_DATA);
        rlast_d  = rvalid_d && (cnt_d == len_d);
        if (rvalid_d && hit_d && !rerr_d) begin
            rdata_d = line_q[idx_d];
        end else begin
            rdata_d = BEAT_ZERO;
        end
        rresp_d  = (rvalid_d && rerr_d) ? 4'd2 : 4'd0;
        bvalid_d = (state_d == S_B_RESP);
        bresp_d  = (bvalid_d && (werr_d || inj_s)) ? 2'd2 : 2'd0;
    end

    // State, line storage and registered outputs.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            state_q  <= S_IDLE;
            line_q   <= {BEATS3_ZERO, BEAT_ZERO};
            tag_q    <= {(AW-6){1'b0}};
            valid_q  <= 1'b0;
            idx_q    <= 2'd0;
            len_q    <= 8'd0;
            cnt_q    <= 8'd0;
            delay_q  <= DLY_ZERO;
            hit_q    <= 1'b0;
            rerr_q   <= 1'b0;
            werr_q   <= 1'b0;
            rdata_q  <= BEAT_ZERO;
            rresp_q  <= 4'd0;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q  <= 2'd0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            delay_q  <= delay_d;
            hit_q    <= hit_d;
            rerr_q   <= rerr_d;
            werr_q   <= werr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign o_awready    = (state_q == S_IDLE);
    assign o_arready    = (state_q == S_IDLE) && !i_awvalid;
    assign o_wready     = (state_q == S_W_DATA);
    assign o_busy       = (state_q != S_IDLE);
    assign o_rdata      = rdata_q;
    assign o_rresp      = rresp_q;
    assign o_rlast      = rlast_q;
    assign o_rvalid     = rvalid_q;
    assign o_bresp      = bresp_q;
    assign o_bvalid     = bvalid_q;
    assign o_cache_line = line_q;
    assign o_line_addr  = {tag_q, 6'd0};

endmodule

// File: tb/tb_passive_line_responder.sv
// Directed bench for passive_line_responder: reset state, read miss, write
// then wrap-ordered read, AW/AR collision, byte strobes, read latency with
// rready stalls, illegal burst lengths, reset mid-burst and error inject.
module tb_passive_line_responder;

    logic          ace_aclk = 1'b0;
    logic          ace_areset;
    logic [43:0]   i_araddr;
    logic [7:0]    i_arlen;
    logic          i_arvalid;
    logic          o_arready;
    logic [127:0]  o_rdata;
    logic [3:0]    o_rresp;
    logic          o_rlast;
    logic          o_rvalid;
    logic          i_rready;
    logic          i_rack;
    logic [43:0]   i_awaddr;
    logic [7:0]    i_awlen;
    logic          i_awvalid;
    logic          o_awready;
    logic [127:0]  i_wdata;
    logic [15:0]   i_wstrb;
    logic          i_wlast;
    logic          i_wvalid;
    logic          o_wready;
    logic [1:0]    o_bresp;
    logic          o_bvalid;
    logic          i_bready;
    logic          i_wack;
    logic [7:0]    i_delay;
    logic          i_err_inject;
    logic [511:0]  o_cache_line;
    logic [43:0]   o_line_addr;
    logic          o_busy;

    passive_line_responder dut (
        .ace_aclk(ace_aclk), .ace_areset(ace_areset),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
        .i_rready(i_rready), .i_rack(i_rack),
        .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_wack(i_wack), .i_delay(i_delay), .i_err_inject(i_err_inject),
        .o_cache_line(o_cache_line), .o_line_addr(o_line_addr), .o_busy(o_busy)
    );

    always #5 ace_aclk = ~ace_aclk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] wd [4];
    logic [127:0] exp_line [4];
    logic [127:0] rd_data [256];
    logic [3:0]   rd_resp [256];
    logic         rd_last [256];
    int           rd_n;
    int           stall_bad;
    bit           rd_to;
    int           rv_lat;
    logic [1:0]   b_resp;
    bit           w_to;

    // Issue AR at a negedge, then measure cycles until rvalid is visible.
    task automatic ar_issue(input logic [43:0] addr, input logic [7:0] len, input logic [7:0] dly);
        int n;
        n = 0;
        i_araddr = addr; i_arlen = len; i_delay = dly; i_arvalid = 1'b1;
        while (o_arready !== 1'b1 && n < 100) begin @(negedge ace_aclk); n++; end
        @(negedge ace_aclk);
        i_arvalid = 1'b0;
        rv_lat = 1;
        while (o_rvalid !== 1'b1 && rv_lat < 100) begin @(negedge ace_aclk); rv_lat++; end
    endtask

    // Wait for rvalid if needed, collect R beats until rlast, then pulse RACK.
    task automatic r_collect(input bit toggle);
        int k;
        bit done;
        bit have_prev;
        logic [127:0] prev;
        rd_n = 0; k = 0; done = 1'b0; have_prev = 1'b0; stall_bad = 0; prev = 128'd0;
        while (!done && k < 700) begin
            i_rready = toggle ? (k % 2 == 0) : 1'b1;
            if (o_rvalid === 1'b1) begin
                if (have_prev && o_rdata !== prev) stall_bad++;
                if (i_rready) begin
                    rd_data[rd_n] = o_rdata; rd_resp[rd_n] = o_rresp; rd_last[rd_n] = o_rlast;
                    rd_n++; have_prev = 1'b0;
                    if (o_rlast === 1'b1 || rd_n >= 256) done = 1'b1;
                end else begin
                    prev = o_rdata; have_prev = 1'b1;
                end
            end
            @(negedge ace_aclk);
            k++;
        end
        i_rready = 1'b0;
        rd_to = !done;
        i_rack = 1'b1;
        @(negedge ace_aclk);
        i_rack = 1'b0;
    endtask

    // Drive W beats from wd[], take the B response, then pulse WACK.
    task automatic w_data_phase(input int nbeats, input int last_at, input logic [15:0] strb);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            i_wdata = wd[b % 4]; i_wstrb = strb; i_wlast = (b == last_at); i_wvalid = 1'b1;
            n = 0;
            while (o_wready !== 1'b1 && n < 100) begin @(negedge ace_aclk); n++; end
            if (n >= 100) w_to = 1'b1;
            @(negedge ace_aclk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        i_bready = 1'b1;
        n = 0;
        while (o_bvalid !== 1'b1 && n < 100) begin @(negedge ace_aclk); n++; end
        if (n >= 100) w_to = 1'b1;
        b_resp = o_bresp;
        @(negedge ace_aclk);
        i_bready = 1'b0;
        i_wack = 1'b1;
        @(negedge ace_aclk);
        i_wack = 1'b0;
    endtask

    task automatic w_burst(input logic [43:0] addr, input logic [7:0] len, input int nbeats,
                           input int last_at, input logic [15:0] strb);
        int n;
        w_to = 1'b0; n = 0;
        i_awaddr = addr; i_awlen = len; i_awvalid = 1'b1;
        while (o_awready !== 1'b1 && n < 100) begin @(negedge ace_aclk); n++; end
        if (n >= 100) w_to = 1'b1;
        @(negedge ace_aclk);
        i_awvalid = 1'b0;
        w_data_phase(nbeats, last_at, strb);
    endtask

    task automatic test_reset;
        ace_areset = 1'b1;
        repeat (3) @(negedge ace_aclk);
        n_checks++; if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", o_rvalid); end
        n_checks++; if (o_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %0b want 0", o_bvalid); end
        n_checks++; if (o_rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %0b want 0", o_rlast); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
        n_checks++; if (o_rdata !== 128'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
        n_checks++; if (o_bresp !== 2'd0 || o_rresp !== 4'd0) begin n_fail++; $display("FAIL reset_resp: got b=%0d r=%0d want 0", o_bresp, o_rresp); end
        n_checks++; if (o_cache_line !== 512'd0) begin n_fail++; $display("FAIL reset_line: got %h want 0", o_cache_line); end
        n_checks++; if (o_line_addr !== 44'd0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", o_line_addr); end
        ace_areset = 1'b0;
        @(negedge ace_aclk);
        n_checks++; if (o_arready !== 1'b1 || o_awready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got ar=%0b aw=%0b want 1/1", o_arready, o_awready); end
    endtask

    task automatic test_read_miss;
        ar_issue(44'h1000, 8'd3, 8'd0);
        n_checks++; if (rv_lat !== 1) begin n_fail++; $display("FAIL t1_latency: got %0d want 1", rv_lat); end
        r_collect(1'b0);
        n_checks++; if (rd_to !== 1'b0 || rd_n !== 4) begin n_fail++; $display("FAIL t1_beats: got %0d (to=%0b) want 4", rd_n, rd_to); end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== 128'd0 || rd_resp[b] !== 4'd0 || rd_last[b] !== (b == 3)) begin
                n_fail++; $display("FAIL t1_beat%0d: got d=%h r=%0d l=%0b want 0/0/%0b", b, rd_data[b], rd_resp[b], rd_last[b], (b == 3));
            end
        end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after_rack: got %0b want 0", o_busy); end
    endtask

    task automatic test_write_wrap;
        for (int i = 0; i < 4; i++) begin wd[i] = {32'hA0A0_0000 + 32'(i), 32'h1111_1111, 32'h2222_2222, 32'hAAAA_0000 + 32'(i)}; exp_line[i] = wd[i]; end
        w_burst(44'h1000, 8'd3, 4, 3, 16'hFFFF);
        n_checks++; if (w_to !== 1'b0 || b_resp !== 2'd0) begin n_fail++; $display("FAIL t2_bresp: got %0d (to=%0b) want 0", b_resp, w_to); end
        n_checks++; if (o_line_addr !== 44'h1000) begin n_fail++; $display("FAIL t2_tag: got %h want 1000", o_line_addr); end
        n_checks++; if (o_cache_line !== {exp_line[3], exp_line[2], exp_line[1], exp_line[0]}) begin n_fail++; $display("FAIL t2_line: got %h", o_cache_line); end
        ar_issue(44'h1020, 8'd3, 8'd0);
        r_collect(1'b0);
        n_checks++; if (rd_n !== 4) begin n_fail++; $display("FAIL t2_beats: got %0d want 4", rd_n); end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== exp_line[(2 + b) % 4] || rd_resp[b] !== 4'd0) begin
                n_fail++; $display("FAIL t2_wrap%0d: got %h r=%0d want %h r=0", b, rd_data[b], rd_resp[b], exp_line[(2 + b) % 4]);
            end
        end
        ar_issue(44'h2000, 8'd3, 8'd0);
        r_collect(1'b0);
        n_checks++; if (rd_n !== 4 || rd_data[0] !== 128'd0 || rd_data[3] !== 128'd0 || rd_resp[1] !== 4'd0) begin
            n_fail++; $display("FAIL t2_miss: got n=%0d d0=%h d3=%h want 4 zero OKAY beats", rd_n, rd_data[0], rd_data[3]);
        end
    endtask

    task automatic test_collision;
        int n;
        for (int i = 0; i < 4; i++) begin wd[i] = {32'hB0B0_0000 + 32'(i), 32'h3333_3333, 32'h4444_4444, 32'hBBBB_0000 + 32'(i)}; exp_line[i] = wd[i]; end
        i_araddr = 44'h1000; i_arlen = 8'd3; i_delay = 8'd0; i_arvalid = 1'b1;
        i_awaddr = 44'h1000; i_awlen = 8'd3; i_awvalid = 1'b1;
        #1;
        n_checks++; if (o_awready !== 1'b1 || o_arready !== 1'b0) begin n_fail++; $display("FAIL t3_priority: got aw=%0b ar=%0b want 1/0", o_awready, o_arready); end
        @(negedge ace_aclk);
        i_awvalid = 1'b0;
        w_to = 1'b0;
        w_data_phase(4, 3, 16'hFFFF);
        n_checks++; if (w_to !== 1'b0 || b_resp !== 2'd0) begin n_fail++; $display("FAIL t3_bresp: got %0d want 0", b_resp); end
        n = 0;
        while (o_arready !== 1'b1 && n < 100) begin @(negedge ace_aclk); n++; end
        @(negedge ace_aclk);
        i_arvalid = 1'b0;
        rv_lat = 1;
        while (o_rvalid !== 1'b1 && rv_lat < 100) begin @(negedge ace_aclk); rv_lat++; end
        n_checks++; if (rv_lat !== 1) begin n_fail++; $display("FAIL t3_latency: got %0d want 1", rv_lat); end
        r_collect(1'b0);
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== exp_line[b]) begin n_fail++; $display("FAIL t3_data%0d: got %h want %h", b, rd_data[b], exp_line[b]); end
        end
    endtask

    task automatic test_strobe;
        for (int i = 0; i < 4; i++) wd[i] = {32'hC0C0_0000 + 32'(i), 32'h5555_5555, 32'h6666_6666, 32'hC1C2_C300 + 32'(i)};
        w_burst(44'h1010, 8'd3, 4, 3, 16'h000F);
        for (int b = 0; b < 4; b++) exp_line[(1 + b) % 4][31:0] = wd[b][31:0];
        n_checks++; if (w_to !== 1'b0 || b_resp !== 2'd0) begin n_fail++; $display("FAIL strobe_bresp: got %0d want 0", b_resp); end
        n_checks++; if (o_cache_line !== {exp_line[3], exp_line[2], exp_line[1], exp_line[0]}) begin n_fail++; $display("FAIL strobe_line: got %h", o_cache_line); end
    endtask

    task automatic test_delay_stall;
        ar_issue(44'h1000, 8'd3, 8'd5);
        n_checks++; if (rv_lat !== 6) begin n_fail++; $display("FAIL t4_latency: got %0d want 6", rv_lat); end
        r_collect(1'b1);
        n_checks++; if (rd_n !== 4 || rd_to !== 1'b0) begin n_fail++; $display("FAIL t4_beats: got %0d want 4", rd_n); end
        n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL t4_stable: got %0d changes want 0", stall_bad); end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rd_data[b] !== exp_line[b] || rd_last[b] !== (b == 3)) begin
                n_fail++; $display("FAIL t4_data%0d: got %h l=%0b want %h", b, rd_data[b], rd_last[b], exp_line[b]);
            end
        end
    endtask

    task automatic test_bad_len;
        int bad;
        for (int i = 0; i < 4; i++) wd[i] = {96'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0, 32'hD000_0000 + 32'(i)};
        w_burst(44'h1000, 8'd1, 2, 1, 16'hFFFF);
        exp_line[0] = wd[0]; exp_line[1] = wd[1];
        n_checks++; if (b_resp !== 2'd2) begin n_fail++; $display("FAIL t5_bresp_len1: got %0d want 2", b_resp); end
        n_checks++; if (o_cache_line !== {exp_line[3], exp_line[2], exp_line[1], exp_line[0]}) begin n_fail++; $display("FAIL t5_line: got %h", o_cache_line); end
        ar_issue(44'h1000, 8'd1, 8'd0);
        r_collect(1'b0);
        n_checks++; if (rd_n !== 2) begin n_fail++; $display("FAIL t5_rbeats: got %0d want 2", rd_n); end
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (rd_data[b] !== 128'd0 || rd_resp[b] !== 4'd2 || rd_last[b] !== (b == 1)) begin
                n_fail++; $display("FAIL t5_rbeat%0d: got d=%h r=%0d l=%0b want 0/2/%0b", b, rd_data[b], rd_resp[b], rd_last[b], (b == 1));
            end
        end
        for (int i = 0; i < 4; i++) wd[i] = {96'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0, 32'hE000_0000 + 32'(i)};
        w_burst(44'h1000, 8'd3, 2, 1, 16'hFFFF);
        exp_line[0] = wd[0]; exp_line[1] = wd[1];
        n_checks++; if (b_resp !== 2'd2) begin n_fail++; $display("FAIL t5_bresp_early_wlast: got %0d want 2", b_resp); end
        n_checks++; if (o_cache_line !== {exp_line[3], exp_line[2], exp_line[1], exp_line[0]}) begin n_fail++; $display("FAIL t5_line_early: got %h", o_cache_line); end
        ar_issue(44'h1000, 8'd255, 8'd0);
        r_collect(1'b0);
        n_checks++; if (rd_n !== 256) begin n_fail++; $display("FAIL t5_len255_beats: got %0d want 256", rd_n); end
        bad = 0;
        for (int b = 0; b < 256; b++) begin
            if (rd_data[b] !== 128'd0 || rd_resp[b] !== 4'd2 || rd_last[b] !== (b == 255)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t5_len255_content: got %0d bad beats want 0", bad); end
    endtask

    task automatic test_reset_mid_burst;
        ar_issue(44'h1000, 8'd3, 8'd0);
        i_rready = 1'b1;
        @(negedge ace_aclk);
        @(negedge ace_aclk);
        i_rready = 1'b0;
        n_checks++; if (o_rvalid !== 1'b1 || o_rdata !== exp_line[2]) begin n_fail++; $display("FAIL t6_beat2: got v=%0b d=%h want 1/%h", o_rvalid, o_rdata, exp_line[2]); end
        ace_areset = 1'b1;
        #1;
        n_checks++; if (o_rvalid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL t6_async: got v=%0b busy=%0b want 0/0", o_rvalid, o_busy); end
        @(negedge ace_aclk);
        n_checks++; if (o_cache_line !== 512'd0 || o_line_addr !== 44'd0) begin n_fail++; $display("FAIL t6_line: got tag=%h line=%h want 0", o_line_addr, o_cache_line); end
        ace_areset = 1'b0;
        @(negedge ace_aclk);
        n_checks++; if (o_rvalid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL t6_abandon: got v=%0b busy=%0b want 0/0", o_rvalid, o_busy); end
    endtask

    task automatic test_err_inject;
        logic [1:0] want;
`ifdef DEVIL_RESP_ERR_INJECT_EN
        want = 2'd2;
`else
        want = 2'd0;
`endif
        for (int i = 0; i < 4; i++) begin wd[i] = {32'hF0F0_0000 + 32'(i), 64'h7777_7777_8888_8888, 32'hFFFF_0000 + 32'(i)}; exp_line[i] = wd[i]; end
        i_err_inject = 1'b1;
        @(negedge ace_aclk);
        i_err_inject = 1'b0;
        w_burst(44'h3000, 8'd3, 4, 3, 16'hFFFF);
        n_checks++; if (b_resp !== want) begin n_fail++; $display("FAIL inject_bresp: got %0d want %0d", b_resp, want); end
        n_checks++; if (o_cache_line !== {exp_line[3], exp_line[2], exp_line[1], exp_line[0]} || o_line_addr !== 44'h3000) begin
            n_fail++; $display("FAIL inject_line: got tag=%h line=%h", o_line_addr, o_cache_line);
        end
        w_burst(44'h3000, 8'd3, 4, 3, 16'hFFFF);
        n_checks++; if (b_resp !== 2'd0) begin n_fail++; $display("FAIL inject_cleared: got %0d want 0", b_resp); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ace_areset = 1'b1;
        i_araddr = 44'd0; i_arlen = 8'd0; i_arvalid = 1'b0; i_rready = 1'b0; i_rack = 1'b0;
        i_awaddr = 44'd0; i_awlen = 8'd0; i_awvalid = 1'b0;
        i_wdata = 128'd0; i_wstrb = 16'd0; i_wlast = 1'b0; i_wvalid = 1'b0;
        i_bready = 1'b0; i_wack = 1'b0; i_delay = 8'd0; i_err_inject = 1'b0;
        @(negedge ace_aclk);
        test_reset;
        test_read_miss;
        test_write_wrap;
        test_collision;
        test_strobe;
        test_delay_stall;
        test_bad_len;
        test_reset_mid_burst;
        test_err_inject;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
